// File: rtl/iter_counter.sv
// iter_counter: start/stop iteration counter with up/down direction, stall and optional auto-reload
module iter_counter #(
    parameter int WIDTH       = 5,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             en_i,
    input  logic             down_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             tc_o,
    output logic             done_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] term;
    logic             tc;

    // up-runs end at the latched limit, down-runs end at zero
    assign term = dir_q ? '0 : lim_q;
    assign tc   = busy_q && (count_q == term);

    // state register
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // next state: abort wins, auto-reload keeps the run alive at terminal count
    always_comb begin
        state_d = abort_i              ? IDLE :
                  (state_q == IDLE)    ? (start_i ? RUN : IDLE) :
                  (state_q == RUN)     ? ((en_i && tc && !AUTO_RELOAD) ? DONE : RUN) :
                                         IDLE;
    end

    // datapath next values: latch run parameters at start, step or reload while running
    always_comb begin
        lim_d   = lim_q;
        dir_d   = dir_q;
        count_d = count_q;
        if (abort_i) begin
            count_d = '0;
        end else if (state_q == IDLE && start_i) begin
            lim_d   = limit_i;
            dir_d   = down_i;
            count_d = down_i ? limit_i : '0;
        end else if (state_q == RUN && en_i) begin
            count_d = !tc        ? (dir_q ? count_q - 1'b1 : count_q + 1'b1) :
                      AUTO_RELOAD ? (dir_q ? lim_q : '0) :
                                    count_q;
        end
        busy_d = (state_d == RUN);
        done_d = !abort_i && (state_q == RUN) && en_i && tc;
    end

    // datapath registers
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            count_q <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign count_o = count_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign tc_o    = tc;
endmodule

// File: tb/tb_iter_counter.sv
// tb_iter_counter: directed scoreboard bench for iter_counter (plain and auto-reload builds)
module tb_iter_counter;
    localparam int W = 5;

    logic         clk = 1'b0, clr_n = 1'b0, start = 1'b0, abort = 1'b0, en = 1'b0, down = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] count, count_ar;
    logic         busy, tc, done, busy_ar, tc_ar, done_ar;

    always #5 clk = ~clk;

    iter_counter #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut (
        .clk_i(clk), .clr_n_i(clr_n), .start_i(start), .abort_i(abort), .en_i(en),
        .down_i(down), .limit_i(limit), .count_o(count), .busy_o(busy), .tc_o(tc), .done_o(done)
    );

    iter_counter #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk_i(clk), .clr_n_i(clr_n), .start_i(start), .abort_i(abort), .en_i(en),
        .down_i(down), .limit_i(limit), .count_o(count_ar), .busy_o(busy_ar), .tc_o(tc_ar), .done_o(done_ar)
    );

    typedef struct packed {
        logic [W-1:0] c;
        logic         b;
        logic         d;
        logic         t;
    } exp_t;

    exp_t  sb_q[$];
    logic  sel_ar = 1'b0;
    int    tests = 0;
    int    fails = 0;
    string tag = "reset";

    task automatic push(input int c, input logic b, input logic d, input logic t);
        exp_t e;
        e.c = c[W-1:0];
        e.b = b;
        e.d = d;
        e.t = t;
        sb_q.push_back(e);
    endtask

    task automatic check();
        exp_t e, o;
        e = sb_q.pop_front();
        o = sel_ar ? {count_ar, busy_ar, done_ar, tc_ar} : {count, busy, done, tc};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed count=%0d busy=%0b done=%0b tc=%0b, expected count=%0d busy=%0b done=%0b tc=%0b",
                   tag, o.c, o.b, o.d, o.t, e.c, e.b, e.d, e.t);
        end
    endtask

    task automatic cyc(input logic s, input logic a, input logic e_i, input logic dn, input int lim,
                       input int c, input logic b, input logic d, input logic t);
        start = s;
        abort = a;
        en    = e_i;
        down  = dn;
        limit = lim[W-1:0];
        push(c, b, d, t);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        push(0, 0, 0, 0);
        check();
        #1 clr_n = 1'b1;
        tag = "full_up_run";
        cyc(1, 0, 1, 0, 31, 0, 1, 0, 0);
        for (int i = 1; i < 32; i++)
            cyc(i % 4 == 0, 0, 1, i[0], 3, i, 1, 0, i == 31);
        tag = "full_up_done";
        cyc(1, 0, 1, 0, 5, 31, 0, 1, 0);
        tag = "start_in_done_ignored";
        cyc(0, 0, 1, 0, 5, 31, 0, 0, 0);
        tag = "down_stall_start";
        cyc(1, 0, 0, 1, 4, 4, 1, 0, 0);
        tag = "down_stall";
        for (int j = 0; j < 9; j++)
            cyc(0, 0, j % 2 == 1, 0, 9, 4 - (j + 1) / 2, 1, 0, (4 - (j + 1) / 2) == 0);
        tag = "down_done";
        cyc(0, 0, 1, 0, 9, 0, 0, 1, 0);
        tag = "down_idle";
        cyc(0, 0, 1, 0, 9, 0, 0, 0, 0);
        tag = "limit_zero";
        cyc(1, 0, 1, 0, 0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
        tag = "abort_run";
        cyc(1, 0, 1, 0, 10, 0, 1, 0, 0);
        for (int k = 1; k <= 6; k++)
            cyc(0, 0, 1, 0, 10, k, 1, 0, 0);
        tag = "abort_with_start";
        cyc(1, 1, 1, 0, 10, 0, 0, 0, 0);
        tag = "abort_no_done";
        cyc(0, 0, 1, 0, 10, 0, 0, 0, 0);
        tag = "after_abort";
        cyc(1, 0, 1, 0, 2, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 2, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 2, 2, 1, 0, 1);
        cyc(0, 0, 1, 0, 2, 2, 0, 1, 0);
        cyc(0, 0, 1, 0, 2, 2, 0, 0, 0);
        sel_ar = 1'b1;
        tag = "reload_abort";
        cyc(0, 1, 1, 0, 2, 0, 0, 0, 0);
        tag = "reload_start";
        cyc(1, 0, 1, 0, 2, 0, 1, 0, 0);
        tag = "reload_run";
        for (int k = 1; k <= 8; k++)
            cyc(0, 0, 1, 0, 7, k % 3, 1, k % 3 == 0, k % 3 == 2);
        tag = "reload_abort_end";
        cyc(0, 1, 1, 0, 2, 0, 0, 0, 0);
        sel_ar = 1'b0;
        tag = "async_reset_run";
        cyc(1, 0, 1, 0, 15, 0, 1, 0, 0);
        for (int k = 1; k <= 7; k++)
            cyc(1, 0, 1, 0, 3, k, 1, 0, 0);
        #2 clr_n = 1'b0;
        #1;
        tag = "async_reset_immediate";
        push(0, 0, 0, 0);
        check();
        tag = "held_in_reset";
        cyc(1, 0, 1, 0, 15, 0, 0, 0, 0);
        #2 clr_n = 1'b1;
        tag = "no_done_after_reset";
        cyc(0, 0, 1, 0, 15, 0, 0, 0, 0);
        tag = "restart_after_reset";
        cyc(1, 0, 1, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 1, 1, 0, 1);
        cyc(0, 0, 1, 0, 1, 1, 0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/iter_counter.md
ITER_COUNTER -- requirements
Module: iter_counter

Interface
REQ-001 Parameter WIDTH, default 5, counter and limit width in bits (legal 2..16).
REQ-002 Parameter AUTO_RELOAD, default 0; 1 = restart the run automatically at terminal count instead of stopping.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel; highest priority after reset.
REQ-007 en  input  1  count enable (stall when 0) during RUN.
REQ-008 down  input  1  direction select, latched at start: 0 = count up, 1 = count down.
REQ-009 limit  input  WIDTH  last index of the run, latched at start; run length = limit+1 enabled cycles.
REQ-010 count  output  WIDTH  registered current index.
REQ-011 busy  output  1  registered; 1 while in RUN.
REQ-012 tc  output  1  combinational; 1 when busy and count equals the terminal value.
REQ-013 done  output  1  registered; one-cycle pulse per completed run.

Function
REQ-014 FSM states IDLE, RUN, DONE, encoded in a registered state variable.
REQ-015 IDLE + start=1 (abort=0): latch limit -> lim_q and down -> dir_q; count <= (down ? limit : 0); next state RUN.
REQ-016 IDLE + start=0: count, busy and done hold at their IDLE values.
REQ-017 Terminal value: lim_q when dir_q=0; 0 when dir_q=1.
REQ-018 RUN + en=0: count and state hold; tc reflects the held count.
REQ-019 RUN + en=1 + tc=0: count <= count+1 (up) or count-1 (down), modulo 2^WIDTH.
REQ-020 RUN + en=1 + tc=1, AUTO_RELOAD=0: count holds the terminal value; next state DONE.
REQ-021 RUN + en=1 + tc=1, AUTO_RELOAD=1: count reloads (0 up, lim_q down); state stays RUN; done pulses the next cycle.
REQ-022 DONE: done=1 and busy=0 for exactly one cycle; count holds the terminal value; next state IDLE unconditionally; start in DONE is ignored.
REQ-023 start while in RUN is ignored; changes to limit or down after the start cycle have no effect until the next accepted start.
REQ-024 limit=0: run lasts exactly one enabled cycle (tc=1 immediately on entering RUN).
REQ-025 limit=2^WIDTH-1 up: counts through all codes with no premature wrap; terminal reached at all-ones.
REQ-026 abort=1 in any state: next state IDLE, count <= 0, busy <= 0, done <= 0; no done pulse for the aborted run; overrides start and en in the same cycle.
REQ-027 busy = (state==RUN); done asserted only via REQ-021/REQ-022.

Reset
REQ-028 clr_n=0 immediately forces state IDLE, count=0, busy=0, done=0, lim_q=0, dir_q=0, independent of clk.
REQ-029 Reset asserted mid-run discards the run; no done pulse after release.
REQ-030 First start after clr_n deasserts is accepted on the first rising edge with clr_n=1.

Verification
REQ-031 WIDTH=5, limit=31, down=0, en=1: start -> count 0..31 over 32 cycles, tc at count=31, done one cycle later, busy low with done.
REQ-032 limit=4, down=1, en toggled 1,0,1,0...: count 4,4,3,3,...,0; done only after the 5th enabled cycle; tc held high while stalled at 0.
REQ-033 limit=0 up: start -> busy 1 cycle, tc=1 that cycle, done next cycle, count=0.
REQ-034 limit=10, abort at count=6 together with start=1: next cycle IDLE, count=0, busy=0, no done; a following start runs normally.
REQ-035 AUTO_RELOAD=1, limit=2 up: count 0,1,2,0,1,2...; busy stays 1; done pulses every 3rd cycle, one cycle after each tc.
REQ-036 clr_n pulsed low between clock edges at count=7: outputs clear immediately; start asserted mid-run ignored beforehand.
